// File: rtl/spart_baud_gen.sv
// -----------------------------------------------------------------------------
// spart_baud_gen
//
// Baud-rate generator for the mini SPART. A programmable divisor is written
// bytewise: the low byte is staged first, and writing the high byte commits
// both halves to the active divisor in a single cycle. The active divisor sets
// the period of rx_ben (a 16x-style oversampling enable). Every OVERSAMPLE-th
// rx_ben is accompanied by a tx_ben pulse.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst       asynchronous active-high reset
//   enable    run enable; counters hold while low
//   data      bus write data byte
//   write     bus write strobe
//   sel_low   selects the divisor low byte (stage on write, readback)
//   sel_high  selects the divisor high byte (commit on write, readback)
//   dout      committed-divisor readback byte, 0 when no single select is set
//   rx_ben    one-cycle receive sample enable (registered)
//   tx_ben    one-cycle transmit bit enable (registered)
//   div_zero  high while the committed divisor is 0
// -----------------------------------------------------------------------------
module spart_baud_gen #(
    parameter int DIV_WIDTH   = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 326
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] data,
    input  logic       write,
    input  logic       sel_low,
    input  logic       sel_high,
    output logic [7:0] dout,
    output logic       rx_ben,
    output logic       tx_ben,
    output logic       div_zero
);

    localparam int HI_W = DIV_WIDTH - 8;
    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [DIV_WIDTH-1:0] DEF_DIV  = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DEF_CNT  = DEF_DIV - 1'b1;
    localparam logic [7:0]           DEF_LOW  = DEF_DIV[7:0];
    localparam logic                 DEF_ZERO = (DEFAULT_DIV == 0);
    localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);

    logic [DIV_WIDTH-1:0] divisor_reg, divisor_next;
    logic [7:0]           low_stage_reg, low_stage_next;
    logic [DIV_WIDTH-1:0] rx_cnt_reg, rx_cnt_next;
    logic [OS_W-1:0]      os_cnt_reg, os_cnt_next;
    logic                 rx_ben_reg, rx_ben_next;
    logic                 tx_ben_reg, tx_ben_next;
    logic                 div_zero_reg, div_zero_next;

    logic                 write_low;
    logic                 commit;
    logic                 run;
    logic [DIV_WIDTH-1:0] new_div;

    // A write with both selects set matches neither decode and is dropped.
    assign write_low = write & sel_low & ~sel_high;
    assign commit    = write & sel_high & ~sel_low;
    assign new_div   = {data[HI_W-1:0], low_stage_reg};
    assign run       = enable & ~div_zero_reg;

    always_comb begin
        divisor_next   = divisor_reg;
        low_stage_next = low_stage_reg;
        rx_cnt_next    = rx_cnt_reg;
        os_cnt_next    = os_cnt_reg;
        div_zero_next  = div_zero_reg;
        // Pulses are single-cycle: they only go high on the terminal step.
        rx_ben_next    = 1'b0;
        tx_ben_next    = 1'b0;

        if (write_low) begin
            low_stage_next = data;
        end

        if (commit) begin
            // A commit restarts the period from scratch, regardless of
            // enable, so the first pulse lands exactly new_div edges later.
            divisor_next  = new_div;
            rx_cnt_next   = new_div - 1'b1;
            os_cnt_next   = '0;
            div_zero_next = (new_div == '0);
        end else if (run) begin
            if (rx_cnt_reg == '0) begin
                rx_cnt_next = divisor_reg - 1'b1;
                rx_ben_next = 1'b1;
                if (os_cnt_reg == OS_LAST) begin
                    os_cnt_next = '0;
                    tx_ben_next = 1'b1;
                end else begin
                    os_cnt_next = os_cnt_reg + 1'b1;
                end
            end else begin
                rx_cnt_next = rx_cnt_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor_reg   <= DEF_DIV;
            low_stage_reg <= DEF_LOW;
            rx_cnt_reg    <= DEF_CNT;
            os_cnt_reg    <= '0;
            rx_ben_reg    <= 1'b0;
            tx_ben_reg    <= 1'b0;
            div_zero_reg  <= DEF_ZERO;
        end else begin
            divisor_reg   <= divisor_next;
            low_stage_reg <= low_stage_next;
            rx_cnt_reg    <= rx_cnt_next;
            os_cnt_reg    <= os_cnt_next;
            rx_ben_reg    <= rx_ben_next;
            tx_ben_reg    <= tx_ben_next;
            div_zero_reg  <= div_zero_next;
        end
    end

    // Readback always reflects the committed divisor, never the staged byte.
    always_comb begin
        dout = 8'h00;
        if (sel_low && !sel_high) begin
            dout = divisor_reg[7:0];
        end else if (sel_high && !sel_low) begin
            dout = 8'(divisor_reg[DIV_WIDTH-1:8]);
        end
    end

    assign rx_ben   = rx_ben_reg;
    assign tx_ben   = tx_ben_reg;
    assign div_zero = div_zero_reg;

endmodule

// File: tb/tb_spart_baud_gen.sv
// -----------------------------------------------------------------------------
// Testbench for spart_baud_gen. Two instances share all inputs: one with the
// default 16x oversampling and one with OVERSAMPLE=2. The reference model
// counts enabled, non-zero-divisor edges since the last restart (reset or
// commit); rx_ben is expected whenever that count is a multiple of the
// divisor and tx_ben whenever it is a multiple of OVERSAMPLE*divisor.
// -----------------------------------------------------------------------------
module tb_spart_baud_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [7:0] data = 8'h00;
    logic       write = 1'b0;
    logic       sel_low = 1'b0;
    logic       sel_high = 1'b0;

    logic [7:0] dout, dout2;
    logic       rx_ben, tx_ben, div_zero;
    logic       rx_ben2, tx_ben2, div_zero2;

    spart_baud_gen dut (
        .clk(clk), .rst(rst), .enable(enable), .data(data), .write(write),
        .sel_low(sel_low), .sel_high(sel_high), .dout(dout),
        .rx_ben(rx_ben), .tx_ben(tx_ben), .div_zero(div_zero)
    );

    spart_baud_gen #(.OVERSAMPLE(2)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .data(data), .write(write),
        .sel_low(sel_low), .sel_high(sel_high), .dout(dout2),
        .rx_ben(rx_ben2), .tx_ben(tx_ben2), .div_zero(div_zero2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int unsigned m_div;
    logic [7:0]  m_stage;
    longint      m_n;
    bit          m_rx, m_tx16, m_tx2, m_zero;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_dout();
        if (sel_low && !sel_high) return m_div[7:0];
        if (sel_high && !sel_low) return m_div[15:8];
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_div   = 326;
        m_stage = 8'h46;
        m_n     = 0;
        m_rx    = 0;
        m_tx16  = 0;
        m_tx2   = 0;
        m_zero  = 0;
    endtask

    // Advance the model by one edge using the current inputs, clock the DUTs,
    // then compare every output one time unit after the edge.
    task automatic tick();
        if (write && sel_low && !sel_high) begin
            m_stage = data;
        end
        if (write && sel_high && !sel_low) begin
            m_div  = {16'h0, data, m_stage};
            m_n    = 0;
            m_rx   = 0;
            m_tx16 = 0;
            m_tx2  = 0;
            m_zero = (m_div == 0);
        end else if (enable && m_div != 0) begin
            m_n++;
            m_rx   = (m_n % longint'(m_div)) == 0;
            m_tx16 = (m_n % (16 * longint'(m_div))) == 0;
            m_tx2  = (m_n % (2 * longint'(m_div))) == 0;
        end else begin
            m_rx   = 0;
            m_tx16 = 0;
            m_tx2  = 0;
        end
        @(posedge clk);
        #1;
        chk("rx_ben",    32'(rx_ben),    32'(m_rx));
        chk("tx_ben",    32'(tx_ben),    32'(m_tx16));
        chk("div_zero",  32'(div_zero),  32'(m_zero));
        chk("dout",      32'(dout),      32'(exp_dout()));
        chk("rx_ben_os2", 32'(rx_ben2),  32'(m_rx));
        chk("tx_ben_os2", 32'(tx_ben2),  32'(m_tx2));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_wr(input bit lo, input bit hi, input logic [7:0] d);
        write    = 1'b1;
        sel_low  = lo;
        sel_high = hi;
        data     = d;
        tick();
        $display("bus write sel_low=%0b sel_high=%0b data=0x%02h -> model divisor=0x%04h stage=0x%02h",
                 lo, hi, d, m_div[15:0], m_stage);
        write    = 1'b0;
        sel_low  = 1'b0;
        sel_high = 1'b0;
    endtask

    initial begin
        int first_rx;
        int first_tx;

        // ---------------- reset state ----------------
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rx_ben",   32'(rx_ben),   32'd0);
        chk("reset_tx_ben",   32'(tx_ben),   32'd0);
        chk("reset_div_zero", 32'(div_zero), 32'd0);
        sel_low = 1'b1;
        #1;
        chk("reset_dout_low", 32'(dout), 32'h46);
        sel_low  = 1'b0;
        sel_high = 1'b1;
        #1;
        chk("reset_dout_high", 32'(dout), 32'h01);
        sel_high = 1'b0;
        rst      = 1'b0;
        enable   = 1'b1;
        $display("reset released, divisor 326");

        // ---------------- default divisor timing ----------------
        first_rx = 0;
        first_tx = 0;
        for (int cyc = 1; cyc <= 5300; cyc++) begin
            tick();
            if (rx_ben && first_rx == 0) first_rx = cyc;
            if (tx_ben && first_tx == 0) first_tx = cyc;
        end
        chk("first_rx_edge", 32'(first_rx), 32'd326);
        chk("first_tx_edge", 32'(first_tx), 32'd5216);
        $display("default run: first rx_ben edge %0d, first tx_ben edge %0d", first_rx, first_tx);

        // ---------------- staged low byte, then commit 4 ----------------
        bus_wr(1'b1, 1'b0, 8'h04);
        sel_low = 1'b1;
        tick();
        chk("low_only_readback", 32'(dout), 32'h46);
        sel_low = 1'b0;
        bus_wr(1'b0, 1'b1, 8'h00);
        first_rx = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (rx_ben && first_rx == 0) first_rx = cyc;
        end
        chk("div4_first_rx", 32'(first_rx), 32'd4);
        run(200);

        // ---------------- zero divisor ----------------
        bus_wr(1'b1, 1'b0, 8'h00);
        bus_wr(1'b0, 1'b1, 8'h00);
        chk("div_zero_set", 32'(div_zero), 32'd1);
        run(1000);
        bus_wr(1'b1, 1'b0, 8'h03);
        bus_wr(1'b0, 1'b1, 8'h00);
        chk("div_zero_clear", 32'(div_zero), 32'd0);
        run(50);

        // ---------------- divisor 8 with an enable gap ----------------
        bus_wr(1'b1, 1'b0, 8'h08);
        bus_wr(1'b0, 1'b1, 8'h00);
        run(13);
        enable = 1'b0;
        $display("enable dropped for 20 cycles");
        run(20);
        enable = 1'b1;
        run(300);

        // ---------------- both selects: ignored ----------------
        bus_wr(1'b1, 1'b1, 8'hFF);
        sel_low  = 1'b1;
        sel_high = 1'b1;
        tick();
        chk("both_sel_dout", 32'(dout), 32'h00);
        sel_high = 1'b0;
        tick();
        chk("both_sel_div_kept", 32'(dout), 32'h08);
        sel_low = 1'b0;
        bus_wr(1'b0, 1'b1, 8'h00);
        sel_low = 1'b1;
        tick();
        chk("recommit_stage_kept", 32'(dout), 32'h08);
        sel_low = 1'b0;
        run(50);

        // ---------------- divisor 1 ----------------
        bus_wr(1'b1, 1'b0, 8'h01);
        bus_wr(1'b0, 1'b1, 8'h00);
        run(10);
        chk("div1_rx_high", 32'(rx_ben), 32'd1);

        // ---------------- asynchronous reset mid-period ----------------
        rst = 1'b1;
        #1;
        chk("async_rst_rx_ben",  32'(rx_ben),  32'd0);
        chk("async_rst_tx_ben",  32'(tx_ben),  32'd0);
        chk("async_rst_rx_ben2", 32'(rx_ben2), 32'd0);
        sel_low = 1'b1;
        #1;
        chk("async_rst_dout", 32'(dout), 32'h46);
        sel_low = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        $display("mid-period reset applied, divisor restored");
        run(700);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 99) < 5) enable = ~enable;
            if (r < 3) begin
                bus_wr(1'b1, 1'b0, 8'($urandom_range(0, 23)));
            end else if (r < 6) begin
                bus_wr(1'b0, 1'b1, ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00);
            end else if (r < 7) begin
                bus_wr(1'b1, 1'b1, 8'($urandom_range(0, 255)));
            end else begin
                write    = 1'b0;
                data     = 8'($urandom_range(0, 255));
                sel_low  = 1'($urandom_range(0, 1));
                sel_high = 1'($urandom_range(0, 1));
                tick();
                sel_low  = 1'b0;
                sel_high = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
